// File: rtl/pulse_seq_if.sv
// ============================================================================
// Module   : pulse_seq_if
// Purpose  : Command/status bundle between the logic-analyzer bank and the
//            pulse sequencer. Optional IRQ lines exist only when
//            PULSE_SEQ_IRQ_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pulse_seq_if #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) ();
  logic             la_oenb_i;
  logic             cfg_wr_i;
  logic [1:0]       cfg_sel_i;
  logic [CNT_W-1:0] cfg_data_i;
  logic             start_i;
  logic             abort_i;
  logic             pulse_o;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [NUM_W-1:0] pulse_cnt_o;
`ifdef PULSE_SEQ_IRQ_EN
  logic             irq_o;
  logic             irq_clr_i;
`endif

  // LA side: issues commands, observes status
  modport master (
    output la_oenb_i, cfg_wr_i, cfg_sel_i, cfg_data_i, start_i, abort_i,
`ifdef PULSE_SEQ_IRQ_EN
    output irq_clr_i,
    input  irq_o,
`endif
    input  pulse_o, busy_o, done_o, err_o, pulse_cnt_o
  );

  // Sequencer side
  modport slave (
    input  la_oenb_i, cfg_wr_i, cfg_sel_i, cfg_data_i, start_i, abort_i,
`ifdef PULSE_SEQ_IRQ_EN
    input  irq_clr_i,
    output irq_o,
`endif
    output pulse_o, busy_o, done_o, err_o, pulse_cnt_o
  );
endinterface

`default_nettype wire

// File: rtl/pulse_seq_ctrl.sv
// ============================================================================
// Module   : pulse_seq_ctrl
// Purpose  : Holds WIDTH/PERIOD/COUNT/DELAY configuration written over LA
//            lines and runs a pulse-burst FSM driving pulse_o, with status
//            reported back to the LA bank.
//            Optional feature macro: PULSE_SEQ_IRQ_EN (sticky irq_o set on
//            done/err, cleared by irq_clr_i).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pulse_seq_ctrl #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  wire logic  wb_clk_i,
  input  wire logic  wb_rst_i,
  pulse_seq_if.slave bus
);

  localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
  localparam logic [NUM_W-1:0] c_num_one = NUM_W'(1);
  localparam logic [NUM_W-1:0] c_num_max = '1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DELAY = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_pulse;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic [NUM_W-1:0] r_pulse_cnt;

  logic [CNT_W-1:0] r_width;
  logic [CNT_W-1:0] r_period;
  logic [NUM_W-1:0] r_count;
  logic [CNT_W-1:0] r_delay;

  logic             r_start_q;
  logic             r_abort_q;
  logic             r_cfg_wr_q;
  logic [1:0]       r_cfg_sel_q;
  logic [CNT_W-1:0] r_cfg_data_q;

  logic             w_wr_ok;
  logic [CNT_W-1:0] w_width;
  logic [CNT_W-1:0] w_period;
  logic [CNT_W-1:0] w_delay;
  logic             w_cfg_bad;
  logic             w_abort_hit;
  logic             w_start_ok;
  logic             w_err_set;
  logic             w_done_set;
  logic             w_last;
  logic [CNT_W-1:0] w_low_load;
  logic [NUM_W-1:0] w_cnt_inc;

  // Capture LA commands, qualified by the active-low LA enable
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_start_q    <= 1'b0;
      r_abort_q    <= 1'b0;
      r_cfg_wr_q   <= 1'b0;
      r_cfg_sel_q  <= 2'd0;
      r_cfg_data_q <= '0;
    end else begin
      r_start_q    <= bus.start_i  & ~bus.la_oenb_i;
      r_abort_q    <= bus.abort_i  & ~bus.la_oenb_i;
      r_cfg_wr_q   <= bus.cfg_wr_i & ~bus.la_oenb_i;
      r_cfg_sel_q  <= bus.cfg_sel_i;
      r_cfg_data_q <= bus.cfg_data_i;
    end
  end

  // A write landing in the same cycle as a start is visible to that start
  assign w_wr_ok    = r_cfg_wr_q && !r_busy;
  assign w_width    = (w_wr_ok && r_cfg_sel_q == 2'd0) ? r_cfg_data_q : r_width;
  assign w_period   = (w_wr_ok && r_cfg_sel_q == 2'd1) ? r_cfg_data_q : r_period;
  assign w_delay    = (w_wr_ok && r_cfg_sel_q == 2'd3) ? r_cfg_data_q : r_delay;
  assign w_cfg_bad  = (w_width == '0) || (w_period <= w_width);

  assign w_abort_hit = r_abort_q && (r_state != S_IDLE);
  assign w_start_ok  = (r_state == S_IDLE) && r_start_q && !r_abort_q;
  assign w_last      = (r_count != '0) && (r_pulse_cnt >= r_count);
  assign w_err_set   = (r_cfg_wr_q && r_busy) || (w_start_ok && w_cfg_bad);
  assign w_done_set  = (r_state == S_LOW) && !w_abort_hit && (r_cnt == '0) && w_last;
  assign w_low_load  = r_period - r_width - c_cnt_one;
  assign w_cnt_inc   = (r_pulse_cnt == c_num_max) ? r_pulse_cnt : r_pulse_cnt + c_num_one;

  // Configuration registers; writes while a burst is active are dropped
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_width  <= CNT_W'(1);
      r_period <= CNT_W'(2);
      r_count  <= NUM_W'(1);
      r_delay  <= '0;
    end else if (w_wr_ok) begin
      case (r_cfg_sel_q)
        2'd0:    r_width  <= r_cfg_data_q;
        2'd1:    r_period <= r_cfg_data_q;
        2'd2:    r_count  <= r_cfg_data_q[NUM_W-1:0];
        default: r_delay  <= r_cfg_data_q;
      endcase
    end
  end

  // Burst sequencer with registered outputs; counters count down and stop at zero
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_pulse     <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_pulse_cnt <= '0;
    end else begin
      r_done <= w_done_set;
      r_err  <= w_err_set;
      if (w_abort_hit) begin
        r_state <= S_IDLE;
        r_pulse <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_start_ok && !w_cfg_bad) begin
              r_pulse_cnt <= '0;
              r_busy      <= 1'b1;
              if (w_delay != '0) begin
                r_state <= S_DELAY;
                r_cnt   <= w_delay - c_cnt_one;
              end else begin
                r_state <= S_HIGH;
                r_cnt   <= w_width - c_cnt_one;
                r_pulse <= 1'b1;
              end
            end
          end
          S_DELAY: begin
            if (r_cnt == '0) begin
              r_state <= S_HIGH;
              r_cnt   <= r_width - c_cnt_one;
              r_pulse <= 1'b1;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_HIGH: begin
            if (r_cnt == '0) begin
              r_state     <= S_LOW;
              r_cnt       <= w_low_load;
              r_pulse     <= 1'b0;
              r_pulse_cnt <= w_cnt_inc;
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          S_LOW: begin
            if (r_cnt == '0) begin
              if (w_last) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
              end else begin
                r_state <= S_HIGH;
                r_cnt   <= r_width - c_cnt_one;
                r_pulse <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt - c_cnt_one;
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_pulse <= 1'b0;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.pulse_o     = r_pulse;
  assign bus.busy_o      = r_busy;
  assign bus.done_o      = r_done;
  assign bus.err_o       = r_err;
  assign bus.pulse_cnt_o = r_pulse_cnt;

`ifdef PULSE_SEQ_IRQ_EN
  logic r_irq;

  // Sticky interrupt: set on the same edge as done/err, set beats clear
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      r_irq <= 1'b0;
    end else if (w_done_set || w_err_set) begin
      r_irq <= 1'b1;
    end else if (bus.irq_clr_i && !bus.la_oenb_i) begin
      r_irq <= 1'b0;
    end
  end

  assign bus.irq_o = r_irq;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pulse_seq_ctrl.sv
// ============================================================================
// Module   : tb_pulse_seq_ctrl
// Purpose  : Directed bench for pulse_seq_ctrl; expected per-edge outputs come
//            from an analytic burst model and flow through a scoreboard queue.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pulse_seq_ctrl;

  typedef struct {
    logic       pulse;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] cnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sb_q[$];

  pulse_seq_if #(.CNT_W(16), .NUM_W(8)) bus ();

  pulse_seq_ctrl #(.CNT_W(16), .NUM_W(8)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected outputs e edges after the start-sampling edge, from the burst timing alone
  function automatic exp_t model(input int w, input int p, input int c, input int d, input int e);
    exp_t r;
    int   t, k, rr, n;
    r.pulse = 1'b0; r.busy = 1'b0; r.done = 1'b0; r.err = 1'b0; r.cnt = 8'd0;
    if (e <= d) begin
      r.busy = 1'b1;
      return r;
    end
    t  = e - 1 - d;
    k  = t / p;
    rr = t % p;
    if (c != 0 && k >= c) begin
      r.cnt  = 8'(c);
      r.done = (t == c * p);
      return r;
    end
    r.busy  = 1'b1;
    r.pulse = (rr < w);
    n       = k + ((rr >= w) ? 1 : 0);
    r.cnt   = (n > 255) ? 8'd255 : 8'(n);
    return r;
  endfunction

  function automatic exp_t idle_exp(input logic [7:0] cnt, input logic err);
    exp_t r;
    r.pulse = 1'b0; r.busy = 1'b0; r.done = 1'b0; r.err = err; r.cnt = cnt;
    return r;
  endfunction

  // Push the expectation, advance one edge, pop and compare against the DUT
  task automatic step(input string tag, input exp_t e);
    exp_t x;
    sb_q.push_back(e);
    tick();
    x = sb_q.pop_front();
    chk({tag, ".pulse"}, 32'(bus.pulse_o),     32'(x.pulse));
    chk({tag, ".busy"},  32'(bus.busy_o),      32'(x.busy));
    chk({tag, ".done"},  32'(bus.done_o),      32'(x.done));
    chk({tag, ".err"},   32'(bus.err_o),       32'(x.err));
    chk({tag, ".cnt"},   32'(bus.pulse_cnt_o), 32'(x.cnt));
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [15:0] data);
    bus.cfg_wr_i   = 1'b1;
    bus.cfg_sel_i  = sel;
    bus.cfg_data_i = data;
    tick();
    bus.cfg_wr_i   = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start_i = 1'b1;
    tick();
    bus.start_i = 1'b0;
  endtask

  initial begin
    exp_t e;
    bus.la_oenb_i  = 1'b0;
    bus.cfg_wr_i   = 1'b0;
    bus.cfg_sel_i  = 2'd0;
    bus.cfg_data_i = 16'd0;
    bus.start_i    = 1'b0;
    bus.abort_i    = 1'b0;
`ifdef PULSE_SEQ_IRQ_EN
    bus.irq_clr_i  = 1'b0;
`endif

    // Reset state
    repeat (3) tick();
    rst = 1'b0;
    step("reset", idle_exp(8'd0, 1'b0));
`ifdef PULSE_SEQ_IRQ_EN
    chk("reset.irq", 32'(bus.irq_o), 32'd0);
`endif

    // Test 1: W=3 P=5 C=2 D=0
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd1, 16'd5);
    cfg_write(2'd2, 16'd2);
    start_pulse();
    for (int i = 1; i <= 12; i++) step($sformatf("t1.e%0d", i), model(3, 5, 2, 0, i));

    // Test 2: DELAY=4 written in the same cycle as start
    bus.cfg_wr_i = 1'b1; bus.cfg_sel_i = 2'd3; bus.cfg_data_i = 16'd4; bus.start_i = 1'b1;
    tick();
    bus.cfg_wr_i = 1'b0; bus.start_i = 1'b0;
    for (int i = 1; i <= 16; i++) step($sformatf("t2.e%0d", i), model(3, 5, 2, 4, i));

    // Test 3: rejected starts (W==P, then W==0)
    cfg_write(2'd0, 16'd5);
    start_pulse();
    step("t3a.e1", idle_exp(8'd2, 1'b1));
    step("t3a.e2", idle_exp(8'd2, 1'b0));
    cfg_write(2'd0, 16'd0);
    start_pulse();
    step("t3b.e1", idle_exp(8'd2, 1'b1));
    step("t3b.e2", idle_exp(8'd2, 1'b0));

    // Test 4: continuous mode, abort sampled at edge 20
    cfg_write(2'd0, 16'd1);
    cfg_write(2'd1, 16'd2);
    cfg_write(2'd2, 16'd0);
    cfg_write(2'd3, 16'd0);
    start_pulse();
    for (int i = 1; i <= 19; i++) step($sformatf("t4.e%0d", i), model(1, 2, 0, 0, i));
    bus.abort_i = 1'b1;
    step("t4.e20", model(1, 2, 0, 0, 20));
    bus.abort_i = 1'b0;
    step("t4.e21", idle_exp(8'd10, 1'b0));
    step("t4.e22", idle_exp(8'd10, 1'b0));

    // Test 5a: LA disabled -> start, abort-free write of W=0 both ignored
    bus.la_oenb_i = 1'b1;
    bus.cfg_wr_i = 1'b1; bus.cfg_sel_i = 2'd0; bus.cfg_data_i = 16'd0; bus.start_i = 1'b1;
    for (int i = 1; i <= 3; i++) step($sformatf("t5a.e%0d", i), idle_exp(8'd10, 1'b0));
    bus.cfg_wr_i = 1'b0; bus.start_i = 1'b0; bus.la_oenb_i = 1'b0;

    // Test 5b: write while busy -> err, config (W=1) unchanged
    start_pulse();
    step("t5b.e1", model(1, 2, 0, 0, 1));
    bus.cfg_wr_i = 1'b1; bus.cfg_sel_i = 2'd0; bus.cfg_data_i = 16'd7;
    step("t5b.e2", model(1, 2, 0, 0, 2));
    bus.cfg_wr_i = 1'b0;
    e = model(1, 2, 0, 0, 3);
    e.err = 1'b1;
    step("t5b.e3", e);
    step("t5b.e4", model(1, 2, 0, 0, 4));
    step("t5b.e5", model(1, 2, 0, 0, 5));

    // Test 5c: reset mid-HIGH forces outputs low without a clock edge
    rst = 1'b1;
    #1;
    chk("t5c.async_pulse", 32'(bus.pulse_o), 32'd0);
    chk("t5c.async_busy",  32'(bus.busy_o),  32'd0);
    chk("t5c.async_cnt",   32'(bus.pulse_cnt_o), 32'd0);
    tick();
    rst = 1'b0;

    // Test 5d: defaults after reset (W=1 P=2 C=1 D=0)
    start_pulse();
    for (int i = 1; i <= 4; i++) step($sformatf("t5d.e%0d", i), model(1, 2, 1, 0, i));

`ifdef PULSE_SEQ_IRQ_EN
    // Test 6: irq from done, held until clear; clear coincident with done loses
    bus.irq_clr_i = 1'b1;
    tick();
    bus.irq_clr_i = 1'b0;
    chk("t6.pre_irq", 32'(bus.irq_o), 32'd0);
    cfg_write(2'd0, 16'd3);
    cfg_write(2'd1, 16'd5);
    cfg_write(2'd2, 16'd2);
    start_pulse();
    for (int i = 1; i <= 10; i++) begin
      step($sformatf("t6a.e%0d", i), model(3, 5, 2, 0, i));
      chk($sformatf("t6a.irq%0d", i), 32'(bus.irq_o), 32'd0);
    end
    step("t6a.e11", model(3, 5, 2, 0, 11));
    chk("t6a.irq11", 32'(bus.irq_o), 32'd1);
    step("t6a.e12", model(3, 5, 2, 0, 12));
    chk("t6a.irq12", 32'(bus.irq_o), 32'd1);
    bus.irq_clr_i = 1'b1;
    tick();
    bus.irq_clr_i = 1'b0;
    chk("t6a.irq_clr", 32'(bus.irq_o), 32'd0);
    start_pulse();
    for (int i = 1; i <= 10; i++) step($sformatf("t6b.e%0d", i), model(3, 5, 2, 0, i));
    bus.irq_clr_i = 1'b1;
    step("t6b.e11", model(3, 5, 2, 0, 11));
    bus.irq_clr_i = 1'b0;
    chk("t6b.irq11", 32'(bus.irq_o), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
